branch_resolve_unit: RTL and testbench
======================================

// Module: branch_resolve_unit
// PURPOSE
// - ID-stage partner of the dynamic branch predictor: carries each IF-stage prediction through the IF/ID boundary.
// - Compares the prediction with the resolved branch outcome in ID.
// - Drives the predictor's training inputs (update PC, was_branch, actual_taken, actual_target, mispredicted).
// - Issues PC redirect + IF/ID flush on a mispredict; keeps saturating branch/mispredict counters.
// PARAMETERS
// - PC_W   16  PC / target width
// - IDX_W  4   predictor index width (low PC bits forwarded as update index)
// - CNT_W  16  performance counter width
// PORTS
// - clk               in   1      clock, rising edge
// - rst_n             in   1      synchronous reset, active low
// - if_valid          in   1      IF holds a real instruction this cycle
// - if_pc             in   PC_W   PC of IF instruction
// - if_pred_taken     in   1      predictor output for if_pc
// - if_pred_target    in   PC_W   predictor target for if_pc
// - pipe_stall        in   1      external hazard stall: hold IF/ID
// - id_is_branch      in   1      ID instruction is a conditional branch
// - id_flags_ready    in   1      condition flags valid for ID branch
// - id_cond_met       in   1      branch condition true (actual taken)
// - id_target         in   PC_W   computed branch target
// - upd_en            out  1      was_branch to predictor (registered)
// - upd_pc_idx        out  IDX_W  IF_ID PC index for training
// - upd_taken         out  1      actual_taken to predictor
// - upd_target        out  PC_W   actual_target to predictor
// - upd_mispredicted  out  1      branch_mispredicted to predictor
// - redirect_valid    out  1      PC must load redirect_pc (combinational)
// - redirect_pc       out  PC_W   corrected fetch PC
// - flush_if_id       out  1      squash IF/ID next edge (== redirect_valid)
// - stall_front       out  1      hold PC + IF/ID while waiting for flags
// - branch_cnt        out  CNT_W  resolved branches, saturating
// - mispred_cnt       out  CNT_W  mispredictions, saturating
// BEHAVIOUR
// - Reset (rst_n=0 at edge): all outputs 0, state RUN, IF/ID pred reg invalid, counters 0.
// - Pred reg {valid, pc, pred_taken, pred_target} loads from IF when !(pipe_stall|stall_front).
// - On flush_if_id the pred reg valid clears; flush beats stall when both are active.
// - FSM states RUN / WAIT / RECOVER.
//   - RUN: if valid & id_is_branch & !id_flags_ready -> WAIT, stall_front=1.
//     - Otherwise resolve this cycle.
//   - WAIT: stall_front=1 until id_flags_ready, then resolve this cycle -> RUN (or RECOVER).
//   - RECOVER: one cycle after a redirect; no resolution, pred reg loads new fetch -> RUN.
// - Resolve (valid instr, not already resolved):
//   - act = id_is_branch & id_cond_met.
//   - mis = (act != pred_taken) | (act & pred_taken & id_target != pred_target).
//   - A non-branch predicted taken counts as mis; it is not counted as a branch.
// - On mis:
//   - redirect_valid = flush_if_id = 1 in the resolve cycle.
//   - redirect_pc = act ? id_target : pc + 2 (PC_W wrap-around, no carry out).
// - Training: upd_* registered, appear exactly 1 cycle after resolve, and pulse for 1 cycle.
//   - upd_en = id_is_branch.
//   - upd_mispredicted = mis.
//   - upd_pc_idx = pc[IDX_W:1].
// - Each instruction resolves once: a per-entry resolved bit blocks re-resolve while pipe_stall holds IF/ID.
// - Counters: branch_cnt += id_is_branch, mispred_cnt += mis, both on resolve; saturate at all-ones.
// - rst_n low mid-WAIT/RECOVER: immediate return to RUN, pending update dropped.
// STRUCTURE
// - Shared package bpu_pkg: state enum brs_state_t {RUN, WAIT, RECOVER}.
// - bpu_pkg also holds typedef pred_entry_t {valid, resolved, pc, taken, target} and the PC_INC=2 constant.
// - One sub-module, sat_counter (CNT_W param, inc, clear), instantiated twice.
// TESTING
// - Reset: rst_n=0 for 2 clk with if_valid=1 -> every output 0; state RUN after release.
// - Correct not-taken: pc=0x0002, pred 0, branch, cond 0 -> no redirect.
//   - Next cycle upd_en=1, upd_taken=0, upd_mispredicted=0, upd_pc_idx=1.
// - Taken mispredict: pc=0x0006, pred 0, cond 1, id_target=0x0080 -> redirect_pc=0x0080 and flush same cycle.
//   - Then RECOVER; mispred_cnt=1.
// - Target mismatch: pred taken, target 0x0040, actual 0x00C0 -> redirect 0x00C0, upd_target=0x00C0.
// - Flags late: id_flags_ready low 3 cycles -> stall_front=1 for 3 cycles, one resolve, one upd_en pulse.
// - Wrap + saturation: pc=0xFFFE predicted taken wrongly -> redirect_pc=0x0000.
//   - With CNT_W=2, 5 mispredicts -> mispred_cnt holds 3.

Source files
------------

// File: rtl/bpu_pkg.sv
// Types and constants shared by the branch predictor and its ID-stage resolve unit.
package bpu_pkg;

  localparam int BPU_PC_W = 16;
  localparam int unsigned PC_INC = 2;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    WAIT    = 2'd1,
    RECOVER = 2'd2
  } brs_state_t;

  typedef struct packed {
    logic                valid;
    logic                resolved;
    logic [BPU_PC_W-1:0] pc;
    logic                taken;
    logic [BPU_PC_W-1:0] target;
  } pred_entry_t;

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Fetch/decode inputs and predictor-training/redirect outputs of the branch resolve unit.
interface branch_resolve_unit_if
  import bpu_pkg::*;
#(
  parameter int PC_W  = BPU_PC_W,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
);

  logic             if_valid;
  logic [PC_W-1:0]  if_pc;
  logic             if_pred_taken;
  logic [PC_W-1:0]  if_pred_target;
  logic             pipe_stall;
  logic             id_is_branch;
  logic             id_flags_ready;
  logic             id_cond_met;
  logic [PC_W-1:0]  id_target;

  logic             upd_en;
  logic [IDX_W-1:0] upd_pc_idx;
  logic             upd_taken;
  logic [PC_W-1:0]  upd_target;
  logic             upd_mispredicted;
  logic             redirect_valid;
  logic [PC_W-1:0]  redirect_pc;
  logic             flush_if_id;
  logic             stall_front;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  modport slave (
    input  if_valid, if_pc, if_pred_taken, if_pred_target, pipe_stall,
    input  id_is_branch, id_flags_ready, id_cond_met, id_target,
    output upd_en, upd_pc_idx, upd_taken, upd_target, upd_mispredicted,
    output redirect_valid, redirect_pc, flush_if_id, stall_front,
    output branch_cnt, mispred_cnt
  );

  modport master (
    output if_valid, if_pc, if_pred_taken, if_pred_target, pipe_stall,
    output id_is_branch, id_flags_ready, id_cond_met, id_target,
    input  upd_en, upd_pc_idx, upd_taken, upd_target, upd_mispredicted,
    input  redirect_valid, redirect_pc, flush_if_id, stall_front,
    input  branch_cnt, mispred_cnt
  );

endinterface

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt <= '0;
    end else if (inc && (cnt != {CNT_W{1'b1}})) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// ID-stage branch resolution: checks the carried IF prediction against the real outcome,
// redirects fetch on a mispredict and trains the predictor one cycle later.
module branch_resolve_unit
  import bpu_pkg::*;
#(
  parameter int PC_W  = BPU_PC_W,
  parameter int IDX_W = 4,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  branch_resolve_unit_if.slave bus
);

  localparam logic [1:0] S_RUN     = 2'(RUN);
  localparam logic [1:0] S_WAIT    = 2'(WAIT);
  localparam logic [1:0] S_RECOVER = 2'(RECOVER);

  logic [1:0]       state;
  logic [1:0]       state_nx;
  pred_entry_t      pr;

  logic             pending;
  logic             wait_flags;
  logic             resolve;
  logic             act;
  logic             mis;
  logic             load_en;
  logic [PC_W-1:0]  fall_pc;

  logic             upd_en_p1;
  logic [IDX_W-1:0] upd_pc_idx_p1;
  logic             upd_taken_p1;
  logic [PC_W-1:0]  upd_target_p1;
  logic             upd_mis_p1;
  logic [CNT_W-1:0] branch_cnt;
  logic [CNT_W-1:0] mispred_cnt;

  // ---- ID stage: compare prediction against the resolved outcome ----
  always_comb begin
    pending    = pr.valid & ~pr.resolved & (state != S_RECOVER);
    wait_flags = pending & bus.id_is_branch & ~bus.id_flags_ready;
    resolve    = pending & ~wait_flags;
    act        = bus.id_is_branch & bus.id_cond_met;
    // A taken outcome with a wrong target is as bad as a wrong direction.
    mis        = resolve & ((act != pr.taken) |
                            (act & pr.taken & (bus.id_target != pr.target)));
  end

  assign fall_pc            = pr.pc + PC_W'(PC_INC);
  assign load_en            = ~(bus.pipe_stall | wait_flags);
  assign bus.redirect_valid = mis;
  assign bus.flush_if_id    = mis;
  assign bus.redirect_pc    = mis ? (act ? bus.id_target : fall_pc) : '0;
  assign bus.stall_front    = wait_flags;

  always_comb begin
    state_nx = state;
    case (state)
      S_RUN: begin
        if (wait_flags)  state_nx = S_WAIT;
        else if (mis)    state_nx = S_RECOVER;
      end
      S_WAIT: begin
        if (!wait_flags) state_nx = mis ? S_RECOVER : S_RUN;
      end
      S_RECOVER:         state_nx = S_RUN;
      default:           state_nx = S_RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_RUN;
    end else begin
      state <= state_nx;
    end
  end

  // ---- IF/ID boundary: prediction register (flush wins over any stall) ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pr.valid    <= 1'b0;
      pr.resolved <= 1'b0;
    end else if (mis) begin
      pr.valid    <= 1'b0;
      pr.resolved <= 1'b0;
    end else if (load_en) begin
      pr.valid    <= bus.if_valid;
      pr.resolved <= 1'b0;
      pr.pc       <= bus.if_pc;
      pr.taken    <= bus.if_pred_taken;
      pr.target   <= bus.if_pred_target;
    end else if (resolve) begin
      // Held entry already trained; it must not resolve again while stalled.
      pr.resolved <= 1'b1;
    end
  end

  // ---- Training stage: one-cycle pulse after the resolve cycle ----
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      upd_en_p1     <= 1'b0;
      upd_mis_p1    <= 1'b0;
      upd_taken_p1  <= 1'b0;
      upd_target_p1 <= '0;
      upd_pc_idx_p1 <= '0;
    end else begin
      upd_en_p1     <= resolve & bus.id_is_branch;
      upd_mis_p1    <= mis;
      upd_taken_p1  <= resolve & act;
      upd_target_p1 <= resolve ? bus.id_target : '0;
      upd_pc_idx_p1 <= resolve ? pr.pc[IDX_W:1] : '0;
    end
  end

  assign bus.upd_en           = upd_en_p1;
  assign bus.upd_mispredicted = upd_mis_p1;
  assign bus.upd_taken        = upd_taken_p1;
  assign bus.upd_target       = upd_target_p1;
  assign bus.upd_pc_idx       = upd_pc_idx_p1;

  sat_counter #(.CNT_W(CNT_W)) u_branch_cnt (
    .clk   (clk),
    .clear (~rst_n),
    .inc   (resolve & bus.id_is_branch),
    .cnt   (branch_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_mispred_cnt (
    .clk   (clk),
    .clear (~rst_n),
    .inc   (mis),
    .cnt   (mispred_cnt)
  );

  assign bus.branch_cnt  = branch_cnt;
  assign bus.mispred_cnt = mispred_cnt;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed plus random bench for branch_resolve_unit against an outcome-level reference model.
module tb_branch_resolve_unit;

  logic clk;
  logic rst_n;

  branch_resolve_unit_if #(.PC_W(16), .IDX_W(4), .CNT_W(16)) bus ();
  branch_resolve_unit_if #(.PC_W(16), .IDX_W(4), .CNT_W(2))  bus2 ();

  branch_resolve_unit #(.PC_W(16), .IDX_W(4), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  branch_resolve_unit #(.PC_W(16), .IDX_W(4), .CNT_W(2)) dut2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.if_valid       = bus.if_valid;
  assign bus2.if_pc          = bus.if_pc;
  assign bus2.if_pred_taken  = bus.if_pred_taken;
  assign bus2.if_pred_target = bus.if_pred_target;
  assign bus2.pipe_stall     = bus.pipe_stall;
  assign bus2.id_is_branch   = bus.id_is_branch;
  assign bus2.id_flags_ready = bus.id_flags_ready;
  assign bus2.id_cond_met    = bus.id_cond_met;
  assign bus2.id_target      = bus.id_target;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: the instruction sitting in ID and what training/counters should show.
  logic        m_valid, m_done, m_pt;
  logic [15:0] m_pc, m_ptg;
  logic        e_stall, e_res, e_act, e_mis;
  logic [15:0] e_rpc;
  logic        x_en, x_taken, x_mis;
  logic [3:0]  x_idx;
  logic [15:0] x_tgt;
  int unsigned bc, mc, bc2, mc2;

  logic        s_redir, s_flush, s_stall;
  logic [15:0] s_rpc;
  int          n_upd, n_st;
  logic [15:0] tg [4] = '{16'h0040, 16'h0080, 16'h00C0, 16'hFFF0};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_valid = 0; m_done = 0; m_pt = 0; m_pc = 0; m_ptg = 0;
    x_en = 0; x_taken = 0; x_mis = 0; x_idx = 0; x_tgt = 0;
    bc = 0; mc = 0; bc2 = 0; mc2 = 0;
  endtask

  task automatic model_comb();
    bit pend;
    pend    = m_valid && !m_done;
    e_stall = pend && bus.id_is_branch && !bus.id_flags_ready;
    e_res   = pend && !e_stall;
    e_act   = bus.id_is_branch && bus.id_cond_met;
    e_mis   = e_res && ((e_act != m_pt) || (e_act && bus.id_target != m_ptg));
    if (!e_mis)     e_rpc = 16'h0000;
    else if (e_act) e_rpc = bus.id_target;
    else            e_rpc = m_pc + 16'd2;
  endtask

  task automatic model_edge();
    if (!rst_n) begin
      model_reset();
    end else begin
      x_en    = e_res && bus.id_is_branch;
      x_mis   = e_mis;
      x_taken = e_res && e_act;
      x_tgt   = e_res ? bus.id_target : 16'h0000;
      x_idx   = e_res ? m_pc[4:1] : 4'h0;
      if (e_res && bus.id_is_branch) begin
        if (bc < 65535) bc++;
        if (bc2 < 3) bc2++;
      end
      if (e_mis) begin
        if (mc < 65535) mc++;
        if (mc2 < 3) mc2++;
      end
      if (e_mis) begin
        m_valid = 0;
        m_done  = 0;
      end else if (!(bus.pipe_stall || e_stall)) begin
        m_valid = bus.if_valid;
        m_done  = 0;
        m_pc    = bus.if_pc;
        m_pt    = bus.if_pred_taken;
        m_ptg   = bus.if_pred_target;
      end else if (e_res) begin
        m_done = 1;
      end
    end
  endtask

  task automatic cycle();
    @(negedge clk);
    model_comb();
    s_redir = bus.redirect_valid;
    s_flush = bus.flush_if_id;
    s_stall = bus.stall_front;
    s_rpc   = bus.redirect_pc;
    chk("redirect_valid", bus.redirect_valid, e_mis);
    chk("redirect_pc", bus.redirect_pc, e_rpc);
    chk("flush_if_id", bus.flush_if_id, e_mis);
    chk("stall_front", bus.stall_front, e_stall);
    chk("redirect_valid_c2", bus2.redirect_valid, e_mis);
    @(posedge clk);
    model_edge();
    #1;
    chk("upd_en", bus.upd_en, x_en);
    chk("upd_pc_idx", bus.upd_pc_idx, x_idx);
    chk("upd_taken", bus.upd_taken, x_taken);
    chk("upd_target", bus.upd_target, x_tgt);
    chk("upd_mispredicted", bus.upd_mispredicted, x_mis);
    chk("branch_cnt", bus.branch_cnt, bc);
    chk("mispred_cnt", bus.mispred_cnt, mc);
    chk("branch_cnt_c2", bus2.branch_cnt, bc2);
    chk("mispred_cnt_c2", bus2.mispred_cnt, mc2);
  endtask

  task automatic set_if(input logic v, input logic [15:0] pc, input logic pt, input logic [15:0] ptg);
    bus.if_valid = v; bus.if_pc = pc; bus.if_pred_taken = pt; bus.if_pred_target = ptg;
  endtask

  task automatic set_id(input logic br, input logic rdy, input logic cond, input logic [15:0] tgt);
    bus.id_is_branch = br; bus.id_flags_ready = rdy; bus.id_cond_met = cond; bus.id_target = tgt;
  endtask

  initial begin
    model_reset();
    rst_n = 1'b0;
    bus.pipe_stall = 1'b0;
    set_if(1'b1, 16'h1234, 1'b1, 16'h5678);
    set_id(1'b1, 1'b1, 1'b1, 16'h9ABC);

    // Reset held with a valid fetch: everything reads zero.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_redirect_valid", bus.redirect_valid, 0);
    chk("rst_redirect_pc", bus.redirect_pc, 0);
    chk("rst_flush", bus.flush_if_id, 0);
    chk("rst_stall_front", bus.stall_front, 0);
    chk("rst_upd_en", bus.upd_en, 0);
    chk("rst_upd_pc_idx", bus.upd_pc_idx, 0);
    chk("rst_upd_taken", bus.upd_taken, 0);
    chk("rst_upd_target", bus.upd_target, 0);
    chk("rst_upd_mis", bus.upd_mispredicted, 0);
    chk("rst_branch_cnt", bus.branch_cnt, 0);
    chk("rst_mispred_cnt", bus.mispred_cnt, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Correctly predicted not-taken branch.
    set_if(1, 16'h0002, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(0, 16'h0004, 0, 16'h0000); set_id(1, 1, 0, 16'h0100); cycle();
    chk("nt_redirect", s_redir, 0);
    chk("nt_upd_en", bus.upd_en, 1);
    chk("nt_upd_taken", bus.upd_taken, 0);
    chk("nt_upd_mis", bus.upd_mispredicted, 0);
    chk("nt_upd_idx", bus.upd_pc_idx, 1);

    // Taken branch predicted not-taken.
    set_if(1, 16'h0006, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(1, 16'h0008, 0, 16'h0000); set_id(1, 1, 1, 16'h0080); cycle();
    chk("tk_redirect", s_redir, 1);
    chk("tk_redirect_pc", s_rpc, 16'h0080);
    chk("tk_flush", s_flush, 1);
    chk("tk_mispred_cnt", bus.mispred_cnt, 1);
    set_if(1, 16'h0010, 1, 16'h0040); set_id(1, 1, 1, 16'h0055); cycle();
    chk("recover_no_redirect", s_redir, 0);
    chk("recover_no_upd", bus.upd_en, 0);

    // Right direction, wrong target.
    set_if(0, 16'h0012, 0, 16'h0000); set_id(1, 1, 1, 16'h00C0); cycle();
    chk("tgt_redirect_pc", s_rpc, 16'h00C0);
    chk("tgt_upd_target", bus.upd_target, 16'h00C0);
    chk("tgt_upd_mis", bus.upd_mispredicted, 1);

    // Flags arrive three cycles late.
    set_if(1, 16'h0020, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(1, 16'h0022, 0, 16'h0000); set_id(1, 0, 0, 16'h0030);
    n_st = 0; n_upd = 0;
    repeat (3) begin
      cycle();
      n_st += int'(s_stall);
      n_upd += int'(bus.upd_en);
    end
    set_if(0, 16'h0022, 0, 16'h0000); set_id(1, 1, 0, 16'h0030); cycle();
    chk("late_release_stall", s_stall, 0);
    n_upd += int'(bus.upd_en);
    set_id(0, 1, 0, 16'h0000); cycle();
    n_upd += int'(bus.upd_en);
    chk("late_stall_cycles", n_st, 3);
    chk("late_upd_pulses", n_upd, 1);

    // Resolve once while an external stall holds the entry.
    set_if(1, 16'h0030, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    bus.pipe_stall = 1'b1;
    set_if(1, 16'h0032, 0, 16'h0000); set_id(1, 1, 0, 16'h0050);
    n_upd = 0;
    repeat (3) begin
      cycle();
      n_upd += int'(bus.upd_en);
    end
    bus.pipe_stall = 1'b0;
    set_if(0, 16'h0000, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    n_upd += int'(bus.upd_en);
    chk("hold_upd_pulses", n_upd, 1);

    // Non-branch at 0xFFFE predicted taken: fall-through wraps to zero.
    set_if(1, 16'hFFFE, 1, 16'h1234); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(0, 16'h0000, 0, 16'h0000); set_id(0, 1, 0, 16'h0777); cycle();
    chk("wrap_redirect", s_redir, 1);
    chk("wrap_redirect_pc", s_rpc, 16'h0000);
    chk("wrap_upd_en", bus.upd_en, 0);
    chk("wrap_upd_mis", bus.upd_mispredicted, 1);
    chk("wrap_branch_cnt", bus.branch_cnt, 5);
    chk("wrap_mispred_cnt", bus.mispred_cnt, 3);

    // Two more mispredicts: the 2-bit counter must stick at 3.
    set_if(1, 16'h0040, 1, 16'h0044); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(1, 16'h0042, 0, 16'h0000); set_id(1, 1, 0, 16'h0000); cycle();
    set_if(1, 16'h0050, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(0, 16'h0000, 0, 16'h0000); set_id(1, 1, 1, 16'h0060); cycle();
    chk("sat_mispred_c2", bus2.mispred_cnt, 3);
    chk("sat_branch_c2", bus2.branch_cnt, 3);
    chk("sat_mispred_c16", bus.mispred_cnt, 5);

    // Reset while waiting for flags drops the pending resolve.
    set_if(1, 16'h0070, 0, 16'h0000); set_id(0, 1, 0, 16'h0000); cycle();
    set_if(1, 16'h0072, 0, 16'h0000); set_id(1, 0, 1, 16'h0090); cycle(); cycle();
    chk("rstwait_stall", s_stall, 1);
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    chk("rstwait_upd_en", bus.upd_en, 0);
    chk("rstwait_branch_cnt", bus.branch_cnt, 0);
    set_id(1, 1, 1, 16'h0090); cycle();
    chk("rstwait_no_resolve", s_redir, 0);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      bus.pipe_stall = ($urandom_range(0, 3) == 0);
      set_if($urandom_range(0, 3) != 0, 16'($urandom) & 16'hFFFE, 1'($urandom),
             tg[$urandom_range(0, 3)]);
      set_id(1'($urandom), $urandom_range(0, 3) != 0, 1'($urandom), tg[$urandom_range(0, 3)]);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
